// File: rtl/icache_pkg.sv
// +----------------------------------------------------------------+
// | icache_pkg: shared widths and way helpers for the icache.     |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

package icache_pkg;

  localparam int XLEN                    = 32;
  localparam int ICACHE_WAYS             = 2;
  localparam int ICACHE_SET_BITS_DEFAULT = 6;

  typedef enum logic {
    WAY0 = 1'b0,
    WAY1 = 1'b1
  } way_e;

  function automatic way_e other_way(input way_e w);
    return (w == WAY0) ? WAY1 : WAY0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_if.sv
// +----------------------------------------------------------------+
// | icache_if: fetcher / memory-return bus seen by the icache.    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

interface icache_if;
  import icache_pkg::*;

  logic            fet_icache_enable;
  logic [XLEN-1:0] fet_pc;
  logic            fet_mem_enable;
  logic            mem_inst_ready;
  logic [XLEN-1:0] mem_inst;
  logic            icache_ready;
  logic [XLEN-1:0] icache_inst;

  modport master (
    output fet_icache_enable, fet_pc, fet_mem_enable, mem_inst_ready, mem_inst,
    input  icache_ready, icache_inst
  );

  modport slave (
    input  fet_icache_enable, fet_pc, fet_mem_enable, mem_inst_ready, mem_inst,
    output icache_ready, icache_inst
  );

endinterface

`default_nettype wire

// File: rtl/icache_way.sv
// +----------------------------------------------------------------+
// | icache_way: valid/tag/data arrays of one way, two read ports. |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module icache_way
  import icache_pkg::*;
#(
  parameter int SET_BITS = 6,
  parameter int TAG_W    = XLEN - SET_BITS - 1
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic [SET_BITS-1:0] rd_idx_i,
  input  wire logic [TAG_W-1:0]    rd_tag_i,
  output logic                     rd_hit_o,
  output logic [XLEN-1:0]          rd_data_o,
  input  wire logic [SET_BITS-1:0] pr_idx_i,
  input  wire logic [TAG_W-1:0]    pr_tag_i,
  output logic                     pr_hit_o,
  output logic                     pr_valid_o,
  input  wire logic                we_i,
  input  wire logic [SET_BITS-1:0] wr_idx_i,
  input  wire logic [TAG_W-1:0]    wr_tag_i,
  input  wire logic [XLEN-1:0]     wr_data_i
);

  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [XLEN-1:0]  data_q [SETS];

  assign rd_hit_o   = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o  = data_q[rd_idx_i];
  // Second port probes the pending-fill set for victim selection.
  assign pr_valid_o = valid_q[pr_idx_i];
  assign pr_hit_o   = valid_q[pr_idx_i] && (tag_q[pr_idx_i] == pr_tag_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/icache.sv
// +----------------------------------------------------------------+
// | icache: 2-way set-associative instruction cache, 0-cycle hit. |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int ICACHE_SET_BITS = ICACHE_SET_BITS_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic rdy,
  icache_if.slave   bus
);

  localparam int SETS  = 1 << ICACHE_SET_BITS;
  localparam int TAG_W = XLEN - ICACHE_SET_BITS - 1;

  logic [SETS-1:0]   lru_q, lru_d;
  logic              pend_valid_q, pend_valid_d;
  logic [XLEN-1:1]   pend_addr_q, pend_addr_d;

  logic [ICACHE_SET_BITS-1:0] lk_idx, pd_idx;
  logic [TAG_W-1:0]           lk_tag, pd_tag;

  logic            rd_hit   [ICACHE_WAYS];
  logic [XLEN-1:0] rd_data  [ICACHE_WAYS];
  logic            pr_hit   [ICACHE_WAYS];
  logic            pr_valid [ICACHE_WAYS];
  logic            fill;
  way_e            fill_way;
  way_e            hit_way;

  assign lk_idx = bus.fet_pc[ICACHE_SET_BITS:1];
  assign lk_tag = bus.fet_pc[XLEN-1:ICACHE_SET_BITS+1];
  assign pd_idx = pend_addr_q[ICACHE_SET_BITS:1];
  assign pd_tag = pend_addr_q[XLEN-1:ICACHE_SET_BITS+1];
  assign fill   = rdy && bus.mem_inst_ready && pend_valid_q;

  for (genvar g = 0; g < ICACHE_WAYS; g++) begin : g_way
    icache_way #(
      .SET_BITS (ICACHE_SET_BITS),
      .TAG_W    (TAG_W)
    ) u_way (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx_i   (lk_idx),
      .rd_tag_i   (lk_tag),
      .rd_hit_o   (rd_hit[g]),
      .rd_data_o  (rd_data[g]),
      .pr_idx_i   (pd_idx),
      .pr_tag_i   (pd_tag),
      .pr_hit_o   (pr_hit[g]),
      .pr_valid_o (pr_valid[g]),
      .we_i       (fill && (fill_way == way_e'(g))),
      .wr_idx_i   (pd_idx),
      .wr_tag_i   (pd_tag),
      .wr_data_i  (bus.mem_inst)
    );
  end

  always_comb begin
    hit_way          = rd_hit[0] ? WAY0 : WAY1;
    bus.icache_ready = bus.fet_icache_enable && (rd_hit[0] || rd_hit[1]);
    bus.icache_inst  = '0;
    if (bus.icache_ready) begin
      bus.icache_inst = rd_data[hit_way];
    end
  end

  // Re-use a resident copy first so a refill never creates a duplicate tag.
  always_comb begin
    fill_way = way_e'(lru_q[pd_idx]);
    if (pr_hit[0]) begin
      fill_way = WAY0;
    end else if (pr_hit[1]) begin
      fill_way = WAY1;
    end else if (!pr_valid[0]) begin
      fill_way = WAY0;
    end else if (!pr_valid[1]) begin
      fill_way = WAY1;
    end
  end

  always_comb begin
    lru_d        = lru_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    if (rdy) begin
      if (bus.icache_ready) begin
        lru_d[lk_idx] = other_way(hit_way);
      end
      if (fill) begin
        lru_d[pd_idx] = other_way(fill_way);
        pend_valid_d  = 1'b0;
      end
      if (bus.fet_mem_enable) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = bus.fet_pc[XLEN-1:1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      lru_q        <= lru_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// +----------------------------------------------------------------+
// | tb_icache: directed self-checking bench for the icache.       |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module tb_icache;

  logic clk;
  logic rst_n;
  logic rdy;
  int   checks;
  int   failures;

  icache_if bus ();

  icache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    #3 rst_n = 1'b1;
    idle(1);
  endtask

  task automatic issue(input logic [31:0] pc);
    bus.fet_pc         = pc;
    bus.fet_mem_enable = 1'b1;
    idle(1);
    bus.fet_mem_enable = 1'b0;
  endtask

  task automatic ret(input logic [31:0] word);
    bus.mem_inst       = word;
    bus.mem_inst_ready = 1'b1;
    idle(1);
    bus.mem_inst_ready = 1'b0;
  endtask

  task automatic fill(input logic [31:0] pc, input logic [31:0] word);
    issue(pc);
    ret(word);
  endtask

  // Lookup is combinational; the enable is held over one edge so a hit also ages the LRU.
  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_rdy, input logic [31:0] exp_inst);
    bus.fet_pc            = pc;
    bus.fet_icache_enable = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, 32'(bus.icache_ready), 32'(exp_rdy));
    check_eq({tag, "_inst"}, bus.icache_inst, exp_inst);
    idle(1);
    bus.fet_icache_enable = 1'b0;
  endtask

  initial begin
    checks                = 0;
    failures              = 0;
    rdy                   = 1'b1;
    rst_n                 = 1'b0;
    bus.fet_icache_enable = 1'b1;
    bus.fet_pc            = 32'h0;
    bus.fet_mem_enable    = 1'b0;
    bus.mem_inst_ready    = 1'b0;
    bus.mem_inst          = 32'h0;
    #2;
    check_eq("rst_rdy", 32'(bus.icache_ready), 32'h0);
    check_eq("rst_inst", bus.icache_inst, 32'h0);
    bus.fet_icache_enable = 1'b0;
    do_reset();
    look("post_rst", 32'h0, 1'b0, 32'h0);

    // Basic fill with no same-cycle bypass.
    issue(32'h1000);
    idle(2);
    bus.fet_pc            = 32'h1000;
    bus.fet_icache_enable = 1'b1;
    bus.mem_inst          = 32'h00A00093;
    bus.mem_inst_ready    = 1'b1;
    #1;
    check_eq("no_bypass", 32'(bus.icache_ready), 32'h0);
    idle(1);
    bus.mem_inst_ready    = 1'b0;
    bus.fet_icache_enable = 1'b0;
    look("fill_hit", 32'h1000, 1'b1, 32'h00A00093);
    look("fill_half", 32'h1002, 1'b0, 32'h0);

    // Same-set eviction honours hit-updated LRU.
    do_reset();
    fill(32'h0000, 32'h11111111);
    fill(32'h0080, 32'h22222222);
    look("ev_touch", 32'h0000, 1'b1, 32'h11111111);
    fill(32'h0100, 32'h33333333);
    look("ev_keep", 32'h0000, 1'b1, 32'h11111111);
    look("ev_new", 32'h0100, 1'b1, 32'h33333333);
    look("ev_gone", 32'h0080, 1'b0, 32'h0);

    // Fill lands at the latched address after a redirect.
    do_reset();
    issue(32'h2000);
    bus.fet_pc = 32'h3000;
    idle(1);
    ret(32'h44444444);
    look("redir_old", 32'h2000, 1'b1, 32'h44444444);
    look("redir_new", 32'h3000, 1'b0, 32'h0);

    // Return and new request in the same cycle.
    do_reset();
    issue(32'h4000);
    bus.fet_pc         = 32'h4004;
    bus.fet_mem_enable = 1'b1;
    bus.mem_inst       = 32'h55555555;
    bus.mem_inst_ready = 1'b1;
    idle(1);
    bus.fet_mem_enable = 1'b0;
    bus.mem_inst_ready = 1'b0;
    look("sim_pend", 32'h4004, 1'b0, 32'h0);
    ret(32'h66666666);
    look("sim_first", 32'h4000, 1'b1, 32'h55555555);
    look("sim_second", 32'h4004, 1'b1, 32'h66666666);

    // Refill of a resident line, then LRU replacement in that set.
    do_reset();
    fill(32'h5000, 32'h77777777);
    fill(32'h5000, 32'h88888888);
    fill(32'h5080, 32'h99999999);
    look("refill_a", 32'h5000, 1'b1, 32'h88888888);
    look("refill_b", 32'h5080, 1'b1, 32'h99999999);
    fill(32'h5100, 32'hAAAAAAAA);
    look("refill_evict", 32'h5000, 1'b0, 32'h0);
    look("refill_c", 32'h5100, 1'b1, 32'hAAAAAAAA);
    look("refill_b2", 32'h5080, 1'b1, 32'h99999999);

    // Async reset drops a pending fill.
    do_reset();
    issue(32'h6000);
    #2 rst_n = 1'b0;
    idle(1);
    #3 rst_n = 1'b1;
    idle(1);
    ret(32'hBBBBBBBB);
    look("rstp_addr", 32'h6000, 1'b0, 32'h0);
    look("rstp_zero", 32'h0000, 1'b0, 32'h0);

    // rdy low freezes the pending register and the arrays.
    do_reset();
    rdy = 1'b0;
    issue(32'h7000);
    rdy = 1'b1;
    ret(32'hCCCCCCCC);
    look("frz_req", 32'h7000, 1'b0, 32'h0);
    issue(32'h7000);
    rdy = 1'b0;
    ret(32'hDDDDDDDD);
    look("frz_ret", 32'h7000, 1'b0, 32'h0);
    rdy = 1'b1;
    ret(32'hEEEEEEEE);
    look("frz_done", 32'h7000, 1'b1, 32'hEEEEEEEE);
    ret(32'hFFFFFFFF);
    look("stray_ret", 32'h7000, 1'b1, 32'hEEEEEEEE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache.md
# icache

Two-way set-associative instruction cache directly upstream of the fetcher. Lookup is combinational: the fetcher's `fet_pc` is looked up while `fet_icache_enable` is high, and the result is returned as `icache_ready` / `icache_inst` in the same cycle. On a miss the fetcher fetches from the memory controller. The cache latches the request address and installs the returned instruction, so later fetches of that halfword address hit.

## Interface
- `ICACHE_SET_BITS`, default 6 — log2 of set count (64 sets).
- `clk`  in  1  — clock.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `rdy`  in  1  — global ready; while low, no state changes.
- `fet_icache_enable`  in  1  — lookup request from fetcher.
- `fet_pc`  in  32  — lookup address (halfword aligned).
- `fet_mem_enable`  in  1  — fetcher is issuing a memory fetch at `fet_pc` this cycle.
- `mem_inst_ready`  in  1  — memory controller returns an instruction this cycle.
- `mem_inst`  in  32  — returned instruction word.
- `icache_ready`  out  1  — hit.
- `icache_inst`  out  32  — hit data.

## Operation
- Address split on `fet_pc[31:1]`:
  - index = `pc[ICACHE_SET_BITS:1]`
  - tag = `pc[31:ICACHE_SET_BITS+1]`
  - Bit 0 is ignored.
- Each way entry holds valid, tag and a 32-bit word. The word is stored whole; for compressed instructions the upper half is don't-care, and the fetcher interprets it.
- One LRU bit per set; it points at the victim way.
- Lookup (combinational):
  - `icache_ready` = `fet_icache_enable` && (way0 hit || way1 hit).
  - `icache_inst` = data of the hitting way; otherwise 0.
  - Both ways hitting is impossible by construction (see fill rule).
- Pending-fill register (`pend_valid`, `pend_addr`):
  - Set, with `pend_addr <= fet_pc`, in any rdy cycle with `fet_mem_enable`.
  - Cleared on the rdy cycle where `mem_inst_ready && pend_valid`.
  - If both events occur in the same cycle, the fill writes the OLD `pend_addr` and the register reloads with the new address (`pend_valid` stays 1).
- Fill (rdy && `mem_inst_ready` && `pend_valid`), way selection in priority order:
  1. The way already holding `pend_addr`'s tag in that set: overwrite, no duplicate.
  2. The invalid way, way0 preferred.
  3. The LRU way.
  - Write valid=1, tag, `mem_inst`; set LRU to the other way.
- `mem_inst_ready` with `pend_valid`=0 is ignored; no write.
- Flush is not an input. An in-flight fill is still installed at its latched address, because instruction memory is immutable.
- LRU on hit: rdy && `icache_ready` → LRU of that set <= other way. A fill to the same set in the same cycle takes priority over the hit update.
- Reset (`rst_n` low, asynchronous): all valid bits 0, all LRU 0, `pend_valid` 0, `pend_addr` 0. Outputs are therefore `icache_ready`=0 and `icache_inst`=0. Data and tag arrays need no reset.

## Timing
- Hit latency is 0 cycles: combinational from `fet_pc` / `fet_icache_enable` to outputs.
- A fill written at edge N is visible to lookups from the cycle after edge N. There is no same-cycle bypass from `mem_inst` to `icache_inst`; the fetcher consumes `mem_inst` directly in that cycle.
- Reset mid-fill drops the pending fill; a later `mem_inst_ready` is ignored.
- `rdy` low freezes LRU, arrays and the pending register. Outputs still follow inputs.

## Structure
- Add `` `ICACHE_SET_BITS `` default and `` `ICACHE_WAYS `` (=2) to `global_params.v`. Reuse `` `XLEN ``.
- One sub-module, `icache_way`:
  - Holds the valid/tag/data arrays for one way.
  - Exposes a combinational hit/data read port.
  - Has a single write port (index, tag, data, we).
  - Valid bits are asynchronously cleared.
- `icache` instantiates two ways and owns the LRU array, the pending-fill register and victim selection.

## Test plan
- Post-reset lookup, pc=0x0, enable=1 → `icache_ready`=0, `icache_inst`=0.
- Fill sequence:
  - Stimulus: `fet_mem_enable` at pc=0x1000, then 3 cycles later `mem_inst_ready` with `mem_inst`=0x00A00093.
  - Required: next-cycle lookup 0x1000 → ready=1, inst=0x00A00093; lookup 0x1002 → miss.
- Same-set eviction:
  - Stimulus: fill 0x0000, then 0x0080, then read 0x0000 (LRU→way1), then fill 0x0100 (set_bits=6).
  - Required: 0x0000 and 0x0100 hit; 0x0080 misses.
- Fill after redirect:
  - Stimulus: `fet_mem_enable` at 0x2000; `fet_pc` changes to 0x3000 before `mem_inst_ready`.
  - Required: 0x2000 hits afterwards; 0x3000 misses.
- Simultaneous return/request:
  - Stimulus: `mem_inst_ready` for pending 0x4000 in the same cycle as `fet_mem_enable` at 0x4004.
  - Required: 0x4000 installed; the next `mem_inst_ready` installs at 0x4004.
- Re-fill of a resident address, then a second address in the same set:
  - Stimulus: fill 0x5000 twice with a different word the second time, then fill 0x5080.
  - Required: 0x5000 returns the second word; 0x5000 and 0x5080 both hit (no duplicate entry).
- Reset during pending fill:
  - Stimulus: assert `rst_n`=0 asynchronously while a fill is pending, then release and pulse `mem_inst_ready`.
  - Required: no entry written; all lookups miss.
